// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo_sync write port among NUM_REQ producers.
// A grant lasts until a last beat, a MAX_BURST cap, or IDLE_TIMEOUT cycles without valid.
module fifo_wr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_BURST    = 8,
    parameter int IDLE_TIMEOUT = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            fifo_full,
    output logic                            fifo_cs,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [IW-1:0]   idle_q, idle_d;

    logic [DATA_WIDTH-1:0] slot [NUM_REQ];
    logic                  pick_valid;
    logic [GW-1:0]         pick;
    logic                  release_grant;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        assign slot[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!pick_valid && req_valid[idx]) begin
                pick_valid = 1'b1;
                pick       = GW'(idx);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        beat_d        = beat_q;
        idle_d        = idle_q;
        release_grant = 1'b0;
        req_ready     = '0;
        fifo_cs       = 1'b0;
        fifo_wr_en    = 1'b0;
        fifo_data_in  = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    grant_d = pick;
                    beat_d  = '0;
                    idle_d  = '0;
                end
            end
            GRANT: begin
                fifo_cs            = 1'b1;
                req_ready[grant_q] = !fifo_full;
                fifo_wr_en         = req_valid[grant_q] & !fifo_full;
                if (fifo_wr_en) begin
                    fifo_data_in  = slot[grant_q];
                    beat_d        = beat_q + BW'(1);
                    idle_d        = '0;
                    release_grant = req_last[grant_q] || (beat_q + BW'(1) == BW'(MAX_BURST));
                end else if (!req_valid[grant_q]) begin
                    // Valid-high stalls on a full FIFO hold the counter, so they never time out.
                    idle_d        = idle_q + IW'(1);
                    release_grant = (idle_q + IW'(1) == IW'(IDLE_TIMEOUT));
                end
                if (release_grant) begin
                    state_d = IDLE;
                    ptr_d   = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            idle_q  <= idle_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: bursts, round-robin order, full stalls,
// idle timeout, pointer wrap and asynchronous reset mid-burst.
module tb_fifo_wr_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_last;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         fifo_full;
    logic         fifo_cs;
    logic         fifo_wr_en;
    logic [31:0]  fifo_data_in;
    logic [1:0]   grant_id;
    logic         busy;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(8), .IDLE_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_cs(fifo_cs), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        tick();
        tick();

        chk("rst_busy",  32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_cs",    32'(fifo_cs), 0);
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_data",  fifo_data_in, 0);
        rst_n = 1'b1;
        tick();

        // Single requester, three-beat packet.
        req_data[2*32 +: 32] = 32'hA0;
        req_valid = 4'b0100;
        #1;
        chk("t1_idle_busy",  32'(busy), 0);
        chk("t1_idle_wr_en", 32'(fifo_wr_en), 0);
        tick();
        chk("t1_grant", 32'(grant_id), 2);
        chk("t1_busy",  32'(busy), 1);
        chk("t1_cs",    32'(fifo_cs), 1);
        chk("t1_ready", 32'(req_ready), 32'b0100);
        chk("t1_wr0",   32'(fifo_wr_en), 1);
        chk("t1_d0",    fifo_data_in, 32'hA0);
        tick();
        req_data[2*32 +: 32] = 32'hA1;
        #1;
        chk("t1_wr1", 32'(fifo_wr_en), 1);
        chk("t1_d1",  fifo_data_in, 32'hA1);
        tick();
        req_data[2*32 +: 32] = 32'hA2;
        req_last = 4'b0100;
        #1;
        chk("t1_wr2", 32'(fifo_wr_en), 1);
        chk("t1_d2",  fifo_data_in, 32'hA2);
        tick();
        chk("t1_release_busy", 32'(busy), 0);
        chk("t1_release_wr",   32'(fifo_wr_en), 0);
        req_valid = '0;
        req_last  = '0;

        // Round-robin over four continuous requesters, capped at 8 beats each.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'h100 + 32'(i);
        req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("t2_grant", 32'(grant_id), 32'(exp_order[g]));
            chk("t2_busy",  32'(busy), 1);
            for (int b = 0; b < 8; b++) begin
                chk("t2_wr",   32'(fifo_wr_en), 1);
                chk("t2_data", fifo_data_in, 32'h100 + 32'(exp_order[g]));
                tick();
            end
            chk("t2_bubble", 32'(busy), 0);
        end
        req_valid = '0;

        // Full FIFO mid-burst on requester 1 (pointer now 1).
        req_valid = 4'b0010;
        #1;
        tick();
        chk("t3_grant", 32'(grant_id), 1);
        for (int b = 0; b < 3; b++) begin
            chk("t3_pre_wr", 32'(fifo_wr_en), 1);
            tick();
        end
        fifo_full = 1'b1;
        #1;
        chk("t3_full_ready", 32'(req_ready), 0);
        chk("t3_full_wr",    32'(fifo_wr_en), 0);
        chk("t3_full_cs",    32'(fifo_cs), 1);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("t3_hold_busy", 32'(busy), 1);
            chk("t3_hold_wr",   32'(fifo_wr_en), 0);
        end
        fifo_full = 1'b0;
        #1;
        for (int b = 0; b < 5; b++) begin
            chk("t3_post_wr", 32'(fifo_wr_en), 1);
            tick();
        end
        chk("t3_release", 32'(busy), 0);
        req_valid = '0;

        // Stalled owner 0 times out while requester 3 waits (pointer now 2).
        req_valid = 4'b0001;
        #1;
        tick();
        chk("t4_grant0", 32'(grant_id), 0);
        chk("t4_wr",     32'(fifo_wr_en), 1);
        tick();
        req_valid = 4'b1000;
        #1;
        chk("t4_stall_busy", 32'(busy), 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t4_idle_busy",  32'(busy), 1);
            chk("t4_idle_grant", 32'(grant_id), 0);
        end
        tick();
        chk("t4_timeout", 32'(busy), 0);
        tick();
        chk("t4_grant3", 32'(grant_id), 3);
        chk("t4_busy3",  32'(busy), 1);

        // Requester 3 finishes; pointer wraps to 0 with 0 and 3 both valid.
        req_last  = 4'b1000;
        req_valid = 4'b1001;
        #1;
        chk("t5_wr", 32'(fifo_wr_en), 1);
        tick();
        chk("t5_release", 32'(busy), 0);
        req_last = '0;
        tick();
        chk("t5_wrap_grant", 32'(grant_id), 0);
        chk("t5_wrap_busy",  32'(busy), 1);

        // Async reset in the middle of a burst from requester 1.
        rst_n     = 1'b0;
        req_valid = 4'b0010;
        #2;
        rst_n = 1'b1;
        tick();
        chk("t6_grant1", 32'(grant_id), 1);
        tick();
        chk("t6_mid_wr", 32'(fifo_wr_en), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy",  32'(busy), 0);
        chk("t6_rst_cs",    32'(fifo_cs), 0);
        chk("t6_rst_wr",    32'(fifo_wr_en), 0);
        chk("t6_rst_ready", 32'(req_ready), 0);
        chk("t6_rst_grant", 32'(grant_id), 0);
        req_valid = 4'b0011;
        #1;
        rst_n = 1'b1;
        tick();
        chk("t6_after_grant", 32'(grant_id), 0);
        chk("t6_after_busy",  32'(busy), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one fifo_sync write port among NUM_REQ producers.
- Grants one requester at a time for a burst, ended by last-beat, beat-count cap or idle timeout.
- Drives the FIFO cs/wr_en/data_in and back-pressures requesters from the FIFO full flag.
- Sits directly in front of fifo_sync; the read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 32, beat width; matches the FIFO.
- MAX_BURST, 8, max beats per grant (>=1).
- IDLE_TIMEOUT, 4, consecutive cycles with granted valid low before forced release (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  per-requester last beat of packet, qualified by valid
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  beat accepted when valid&ready
- fifo_full  in  1  FIFO full flag
- fifo_cs  out  1  FIFO chip select
- fifo_wr_en  out  1  FIFO write enable
- fifo_data_in  out  DATA_WIDTH  FIFO write data
- grant_id  out  $clog2(NUM_REQ)  current owner, valid while busy
- busy  out  1  high in GRANT state

Behaviour:
- Reset (async assert, sync-to-clk release): state=IDLE, grant_id=0, priority pointer=0 (requester 0 highest), beat counter=0, idle counter=0. Outputs busy=0, fifo_cs=0, fifo_wr_en=0, req_ready=0, fifo_data_in=0.
- States: IDLE, GRANT.
- IDLE: if any req_valid, pick the first set bit searching upward from pointer, wrapping. At the next edge, grant_id is set to the pick, state becomes GRANT, and both counters clear. No beat transfers in IDLE, so the arbitration latency is 1 cycle.
- GRANT, combinational:
  - fifo_cs=1.
  - req_ready[grant_id] = !fifo_full; all other ready bits are 0.
  - fifo_wr_en = req_valid[grant_id] & !fifo_full.
  - fifo_data_in = req_data slice of grant_id, or 0 when fifo_wr_en=0.
- Beat = fifo_wr_en high at a clock edge; the beat counter increments.
- Release at an edge (to IDLE, pointer = grant_id+1 mod NUM_REQ) when any of these hold:
  - a beat with req_last[grant_id]=1;
  - a beat that makes the count equal MAX_BURST;
  - the idle counter reaches IDLE_TIMEOUT.
- Idle counter: increments each GRANT cycle with req_valid[grant_id]=0. Clears on a beat. Holds while valid=1 and fifo_full=1, so a full FIFO never causes timeout release.
- The release edge returns to IDLE, giving a 1-cycle bubble between grants. A requester is never re-granted back-to-back while another is valid.
- fifo_full is high throughout the grant: no beats, grant held, counters hold.
- Counters saturate-free: the beat counter is $clog2(MAX_BURST+1) bits and the idle counter $clog2(IDLE_TIMEOUT+1) bits. Both clear on grant.
- Non-granted req_valid/req_last/req_data are ignored; requesters keep valid/data stable until ready.
- Pointer wraps from NUM_REQ-1 to 0.
- Reset mid-burst: immediate return to reset state. Beats not yet accepted are not written, and the FIFO is not reset by this block.

Test Plan:
- Single requester: req 2 sends 3 beats 0xA0..0xA2, last on the 3rd, FIFO empty. Expect grant_id=2 one cycle after valid, fifo_wr_en on 3 consecutive cycles with data A0,A1,A2, then busy=0.
- All 4 valid, continuous, no last, MAX_BURST=8. Expect grant order 0,1,2,3,0, each exactly 8 beats, with 1 idle cycle between grants.
- FIFO full: req 1 granted, assert fifo_full for 10 cycles mid-burst. Expect req_ready=0, fifo_wr_en=0, no release. Bursting resumes when full drops and the beat count continues from its prior value.
- Stalled owner: req 0 granted, sends 1 beat, then valid low while req 3 is valid. Expect release after exactly 4 idle cycles, then grant_id=3.
- Pointer wrap: after req 3 releases with reqs 0 and 3 valid, expect next grant_id=0.
- Async reset asserted mid-burst on req 1. Expect busy, fifo_cs, fifo_wr_en and req_ready all 0 immediately. After release, requester 0 wins when 0 and 1 are both valid.
